present_encryptor_ctrl: RTL

//  Sequencer for present_encryptor_top (PRESENT-80 core). Accepts a key and

---
 rtl/present_encryptor_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/present_encryptor_ctrl.sv
// present_encryptor_ctrl: sequencer for the PRESENT-80 encryptor core.
// Caches a key, reloads it before every block, then loads the plaintext,
// waits out the core rounds and holds the ciphertext until it is taken.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   key_i/key_valid_i/key_ready_o   80-bit key handshake from host
//   pt_i/pt_valid_i/pt_ready_o      64-bit plaintext handshake from host
//   ct_o/ct_valid_o/ct_ready_i      64-bit ciphertext handshake to consumer
//   busy_o                       block in flight
//   core_data_o                  core data_i (key or zero-extended block)
//   core_key_load_o              core key_load strobe
//   core_data_load_o             core data_load strobe
//   core_data_i                  core data_o (ciphertext)

module present_encryptor_ctrl #(
   parameter int CORE_LAT = 31,
   parameter int CNT_W    = $clog2(CORE_LAT + 1)
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [79:0] key_i,
   input  logic        key_valid_i,
   output logic        key_ready_o,
   input  logic [63:0] pt_i,
   input  logic        pt_valid_i,
   output logic        pt_ready_o,
   output logic [63:0] ct_o,
   output logic        ct_valid_o,
   input  logic        ct_ready_i,
   output logic        busy_o,
   output logic [79:0] core_data_o,
   output logic        core_key_load_o,
   output logic        core_data_load_o,
   input  logic [63:0] core_data_i
);

   typedef enum logic [2:0] {
      IDLE,
      LOADK,
      LOADD,
      RUN,
      DONE
   } state_e;

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(CORE_LAT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cached_q, cached_d;
   logic [79:0]      key_q, key_d;
   logic [63:0]      pt_q, pt_d;
   logic [63:0]      ct_q, ct_d;
   logic             ctv_q, ctv_d;

   logic             idle;
   logic             key_xfer;
   logic             pt_xfer;

   assign idle        = (state_q == IDLE);
   assign key_ready_o = idle;
   // A key arriving this cycle may unlock the block in the same cycle.
   assign pt_ready_o  = idle & (cached_q | key_valid_i);
   assign key_xfer    = key_valid_i & key_ready_o;
   assign pt_xfer     = pt_valid_i & pt_ready_o;

   assign busy_o     = ~idle;
   assign ct_o       = ct_q;
   assign ct_valid_o = ctv_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         cached_q <= 1'b0;
         key_q    <= '0;
         pt_q     <= '0;
         ct_q     <= '0;
         ctv_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cached_q <= cached_d;
         key_q    <= key_d;
         pt_q     <= pt_d;
         ct_q     <= ct_d;
         ctv_q    <= ctv_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      cached_d         = cached_q;
      key_d            = key_q;
      pt_d             = pt_q;
      ct_d             = ct_q;
      ctv_d            = ctv_q;
      core_data_o      = '0;
      core_key_load_o  = 1'b0;
      core_data_load_o = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (key_xfer) begin
               key_d    = key_i;
               cached_d = 1'b1;
            end
            if (pt_xfer) begin
               pt_d    = pt_i;
               state_d = LOADK;
            end
         end
         // The core consumes its key register during the rounds,
         // so the cached key is pushed again for every block.
         LOADK: begin
            core_key_load_o = 1'b1;
            core_data_o     = key_q;
            state_d         = LOADD;
         end
         LOADD: begin
            core_data_load_o = 1'b1;
            core_data_o      = {16'h0, pt_q};
            cnt_d            = '0;
            state_d          = RUN;
         end
         RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CntLast) begin
               ct_d    = core_data_i;
               ctv_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (ct_ready_i) begin
               ctv_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
